// File: rtl/cp0_tlb_regfile.sv
// cp0_tlb_regfile: CP0 privileged registers, Count/Compare timer, interrupt pending
//   and TLB maintenance (tlbp/tlbr/tlbwi/tlbwr) beside writeback. State updates at the
//   next edge; rdata/cancel/new_pc/we are combinational. No backpressure: strobes are single-cycle commits.
// Ports: i_clk/i_reset; commit strobes i_ex (+exccode/bd/pc/badvaddr/refill), i_eret,
//   i_mtc0_we/i_cp0_waddr/i_cp0_wdata, i_tlbp (+s_found/s_index), i_tlbr, i_tlbwi, i_tlbwr;
//   read port i_cp0_raddr/o_cp0_rdata; TLB read (o_r_index, i_r_*) and write (o_we, o_w_*)
//   ports; o_entryhi_* to the TLB search ports; o_has_int, o_cancel, o_new_pc to the pipeline.
module cp0_tlb_regfile #(
   parameter int          TLBNUM       = 16,
   parameter int          CNT_DIV_LOG2 = 1,
   parameter logic [31:0] EXC_BASE     = 32'hbfc00200,
   localparam int         IDXW         = $clog2(TLBNUM)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [5:0]      i_ext_int_in,
   input  logic            i_ex,
   input  logic [4:0]      i_exccode,
   input  logic            i_bd,
   input  logic [31:0]     i_pc,
   input  logic [31:0]     i_badvaddr,
   input  logic            i_refill,
   input  logic            i_eret,
   input  logic            i_mtc0_we,
   input  logic [7:0]      i_cp0_waddr,
   input  logic [31:0]     i_cp0_wdata,
   input  logic [7:0]      i_cp0_raddr,
   output logic [31:0]     o_cp0_rdata,
   input  logic            i_tlbp,
   input  logic            i_s_found,
   input  logic [IDXW-1:0] i_s_index,
   input  logic            i_tlbr,
   input  logic            i_tlbwi,
   input  logic            i_tlbwr,
   output logic [IDXW-1:0] o_r_index,
   input  logic [18:0]     i_r_vpn2,
   input  logic [7:0]      i_r_asid,
   input  logic            i_r_g,
   input  logic [19:0]     i_r_pfn0,
   input  logic [2:0]      i_r_c0,
   input  logic            i_r_d0,
   input  logic            i_r_v0,
   input  logic [19:0]     i_r_pfn1,
   input  logic [2:0]      i_r_c1,
   input  logic            i_r_d1,
   input  logic            i_r_v1,
   output logic            o_we,
   output logic [IDXW-1:0] o_w_index,
   output logic [18:0]     o_w_vpn2,
   output logic [7:0]      o_w_asid,
   output logic            o_w_g,
   output logic [19:0]     o_w_pfn0,
   output logic [2:0]      o_w_c0,
   output logic            o_w_d0,
   output logic            o_w_v0,
   output logic [19:0]     o_w_pfn1,
   output logic [2:0]      o_w_c1,
   output logic            o_w_d1,
   output logic            o_w_v1,
   output logic [18:0]     o_entryhi_vpn2,
   output logic [7:0]      o_entryhi_asid,
   output logic            o_has_int,
   output logic            o_cancel,
   output logic [31:0]     o_new_pc
);
   localparam logic [IDXW-1:0] RND_TOP = IDXW'(TLBNUM - 1);
   localparam int              PW      = (CNT_DIV_LOG2 > 0) ? CNT_DIV_LOG2 : 1;
   localparam logic [31:0]     EXC_GEN = EXC_BASE + 32'h180;

   localparam logic [7:0] A_INDEX = 8'd0,  A_RANDOM = 8'd8,   A_LO0   = 8'd16, A_LO1   = 8'd24;
   localparam logic [7:0] A_WIRED = 8'd48, A_BADV   = 8'd64,  A_COUNT = 8'd72, A_EHI   = 8'd80;
   localparam logic [7:0] A_CMP   = 8'd88, A_STATUS = 8'd96,  A_CAUSE = 8'd104, A_EPC  = 8'd112;

   logic            r_index_p;
   logic [IDXW-1:0] r_index, r_random, r_wired;
   logic [25:0]     r_lo0, r_lo1;            // {PFN, C, D, V, G}
   logic [18:0]     r_ehi_vpn2;
   logic [7:0]      r_ehi_asid;
   logic [31:0]     r_badvaddr, r_count, r_compare, r_epc;
   logic [7:0]      r_im;
   logic            r_exl, r_ie, r_bd, r_ti;
   logic [5:0]      r_ip_hw;
   logic [1:0]      r_ip_sw;
   logic [4:0]      r_exccode;
   logic [PW-1:0]   r_prediv;

   // Strobe arbitration: ex > eret > TLB ops > mtc0; losers are dropped.
   logic w_tlb_ok, w_do_eret, w_do_tlbp, w_do_tlbr, w_do_tlbwi, w_do_tlbwr, w_do_mtc0;
   assign w_do_eret  = i_eret & ~i_ex;
   assign w_tlb_ok   = ~i_ex & ~i_eret;
   assign w_do_tlbp  = i_tlbp  & w_tlb_ok;
   assign w_do_tlbr  = i_tlbr  & w_tlb_ok;
   assign w_do_tlbwi = i_tlbwi & w_tlb_ok;
   assign w_do_tlbwr = i_tlbwr & w_tlb_ok;
   assign w_do_mtc0  = i_mtc0_we & ~(i_ex | i_eret | i_tlbp | i_tlbr | i_tlbwi | i_tlbwr);

   logic w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_wired, w_wr_count, w_wr_ehi;
   logic w_wr_cmp, w_wr_status, w_wr_cause, w_wr_epc;
   assign w_wr_index  = w_do_mtc0 & (i_cp0_waddr == A_INDEX);
   assign w_wr_lo0    = w_do_mtc0 & (i_cp0_waddr == A_LO0);
   assign w_wr_lo1    = w_do_mtc0 & (i_cp0_waddr == A_LO1);
   assign w_wr_wired  = w_do_mtc0 & (i_cp0_waddr == A_WIRED);
   assign w_wr_count  = w_do_mtc0 & (i_cp0_waddr == A_COUNT);
   assign w_wr_ehi    = w_do_mtc0 & (i_cp0_waddr == A_EHI);
   assign w_wr_cmp    = w_do_mtc0 & (i_cp0_waddr == A_CMP);
   assign w_wr_status = w_do_mtc0 & (i_cp0_waddr == A_STATUS);
   assign w_wr_cause  = w_do_mtc0 & (i_cp0_waddr == A_CAUSE);
   assign w_wr_epc    = w_do_mtc0 & (i_cp0_waddr == A_EPC);

   // TLB refill/invalid/modified (1..3) capture the faulting VPN2; address errors (4,5) too for BadVAddr.
   logic w_exc_tlb, w_exc_addr, w_tick;
   logic [7:0] w_ip;
   assign w_exc_tlb  = i_ex & (i_exccode >= 5'd1) & (i_exccode <= 5'd3);
   assign w_exc_addr = i_ex & (i_exccode >= 5'd1) & (i_exccode <= 5'd5);
   assign w_tick     = (CNT_DIV_LOG2 == 0) ? 1'b1 : (r_prediv == {PW{1'b1}});
   assign w_ip       = {r_ip_hw[5] | r_ti, r_ip_hw[4:0], r_ip_sw};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_index_p  <= 1'b0;
         r_index    <= '0;
         r_random   <= RND_TOP;
         r_wired    <= '0;
         r_lo0      <= '0;
         r_lo1      <= '0;
         r_ehi_vpn2 <= '0;
         r_ehi_asid <= '0;
         r_badvaddr <= '0;
         r_count    <= '0;
         r_compare  <= 32'hffffffff;
         r_epc      <= '0;
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ti       <= 1'b0;
         r_ip_hw    <= '0;
         r_ip_sw    <= '0;
         r_exccode  <= '0;
         r_prediv   <= '0;
      end else begin
         // Random walks down to Wired then wraps to the top; a Wired write restarts it.
         if (w_wr_wired || r_random == r_wired) r_random <= RND_TOP;
         else                                   r_random <= r_random - 1'b1;
         if (w_wr_wired) r_wired <= i_cp0_wdata[IDXW-1:0];

         if (w_do_tlbp) begin
            r_index_p <= ~i_s_found;
            r_index   <= i_s_index;
         end
         if (w_wr_index) r_index <= i_cp0_wdata[IDXW-1:0];

         if (w_do_tlbr) begin
            r_lo0      <= {i_r_pfn0, i_r_c0, i_r_d0, i_r_v0, i_r_g};
            r_lo1      <= {i_r_pfn1, i_r_c1, i_r_d1, i_r_v1, i_r_g};
            r_ehi_vpn2 <= i_r_vpn2;
            r_ehi_asid <= i_r_asid;
         end
         if (w_wr_lo0) r_lo0 <= i_cp0_wdata[25:0];
         if (w_wr_lo1) r_lo1 <= i_cp0_wdata[25:0];
         if (w_wr_ehi) begin
            r_ehi_vpn2 <= i_cp0_wdata[31:13];
            r_ehi_asid <= i_cp0_wdata[7:0];
         end
         if (w_exc_tlb)  r_ehi_vpn2 <= i_badvaddr[31:13];
         // BadVAddr is hardware-captured only; software writes are ignored.
         if (w_exc_addr) r_badvaddr <= i_badvaddr;

         // Nested exceptions (EXL already set) keep the original EPC/BD.
         if (i_ex && !r_exl) begin
            r_bd  <= i_bd;
            r_epc <= i_bd ? i_pc - 32'd4 : i_pc;
         end
         if (i_ex) begin
            r_exccode <= i_exccode;
            r_exl     <= 1'b1;
         end
         if (w_do_eret) r_exl <= 1'b0;
         if (w_wr_status) begin
            r_im  <= i_cp0_wdata[15:8];
            r_exl <= i_cp0_wdata[1];
            r_ie  <= i_cp0_wdata[0];
         end
         if (w_wr_cause) r_ip_sw <= i_cp0_wdata[9:8];
         if (w_wr_epc)   r_epc   <= i_cp0_wdata;
         r_ip_hw <= i_ext_int_in;

         r_prediv <= r_prediv + 1'b1;
         if (w_wr_count)  r_count <= i_cp0_wdata;
         else if (w_tick) r_count <= r_count + 32'd1;

         // A Compare write acknowledges the timer even if Count matches this cycle.
         if (w_wr_cmp) begin
            r_compare <= i_cp0_wdata;
            r_ti      <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   always_comb begin
      o_cp0_rdata = 32'd0;
      case (i_cp0_raddr)
         A_INDEX:  o_cp0_rdata = {r_index_p, {(31-IDXW){1'b0}}, r_index};
         A_RANDOM: o_cp0_rdata = {{(32-IDXW){1'b0}}, r_random};
         A_LO0:    o_cp0_rdata = {6'd0, r_lo0};
         A_LO1:    o_cp0_rdata = {6'd0, r_lo1};
         A_WIRED:  o_cp0_rdata = {{(32-IDXW){1'b0}}, r_wired};
         A_BADV:   o_cp0_rdata = r_badvaddr;
         A_COUNT:  o_cp0_rdata = r_count;
         A_EHI:    o_cp0_rdata = {r_ehi_vpn2, 5'd0, r_ehi_asid};
         A_CMP:    o_cp0_rdata = r_compare;
         A_STATUS: o_cp0_rdata = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
         A_CAUSE:  o_cp0_rdata = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'd0};
         A_EPC:    o_cp0_rdata = r_epc;
         default:  o_cp0_rdata = 32'd0;
      endcase
   end

   always_comb begin
      o_new_pc = EXC_GEN;
      if (i_reset)                          o_new_pc = EXC_GEN;
      else if (i_ex)                        o_new_pc = (i_refill && !r_exl) ? EXC_BASE : EXC_GEN;
      else if (i_eret)                      o_new_pc = r_epc;
      else if (i_tlbr || i_tlbwi || i_tlbwr) o_new_pc = i_pc + 32'd4;
   end

   assign o_cancel       = ~i_reset & (i_ex | i_eret | i_tlbr | i_tlbwi | i_tlbwr);
   assign o_we           = ~i_reset & (w_do_tlbwi | w_do_tlbwr);
   assign o_w_index      = i_tlbwr ? r_random : r_index;
   assign o_r_index      = r_index;
   assign o_w_vpn2       = r_ehi_vpn2;
   assign o_w_asid       = r_ehi_asid;
   assign o_w_g          = r_lo0[0] & r_lo1[0];
   assign o_w_pfn0       = r_lo0[25:6];
   assign o_w_c0         = r_lo0[5:3];
   assign o_w_d0         = r_lo0[2];
   assign o_w_v0         = r_lo0[1];
   assign o_w_pfn1       = r_lo1[25:6];
   assign o_w_c1         = r_lo1[5:3];
   assign o_w_d1         = r_lo1[2];
   assign o_w_v1         = r_lo1[1];
   assign o_entryhi_vpn2 = r_ehi_vpn2;
   assign o_entryhi_asid = r_ehi_asid;
   assign o_has_int      = (|(w_ip & r_im)) & r_ie & ~r_exl;
endmodule

// File: tb/tb_cp0_tlb_regfile.sv
`timescale 1ns/1ps
module tb_cp0_tlb_regfile;
   localparam int          N   = 16;
   localparam int          DIV = 1;
   localparam logic [31:0] EB  = 32'hbfc00200;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   logic        reset, ex, bd, refill, eret, mtc0_we, tlbp, s_found, tlbr, tlbwi, tlbwr;
   logic [5:0]  ext_int_in;
   logic [4:0]  exccode;
   logic [31:0] pc, badvaddr, cp0_wdata, cp0_rdata, new_pc;
   logic [7:0]  cp0_waddr, cp0_raddr, r_asid, w_asid, entryhi_asid;
   logic [3:0]  s_index, r_index, w_index;
   logic [18:0] r_vpn2, w_vpn2, entryhi_vpn2;
   logic        r_g, r_d0, r_v0, r_d1, r_v1, we, w_g, w_d0, w_v0, w_d1, w_v1, has_int, cancel;
   logic [19:0] r_pfn0, r_pfn1, w_pfn0, w_pfn1;
   logic [2:0]  r_c0, r_c1, w_c0, w_c1;

   cp0_tlb_regfile #(.TLBNUM(N), .CNT_DIV_LOG2(DIV), .EXC_BASE(EB)) dut (
      .i_clk(clk), .i_reset(reset), .i_ext_int_in(ext_int_in), .i_ex(ex), .i_exccode(exccode),
      .i_bd(bd), .i_pc(pc), .i_badvaddr(badvaddr), .i_refill(refill), .i_eret(eret),
      .i_mtc0_we(mtc0_we), .i_cp0_waddr(cp0_waddr), .i_cp0_wdata(cp0_wdata),
      .i_cp0_raddr(cp0_raddr), .o_cp0_rdata(cp0_rdata), .i_tlbp(tlbp), .i_s_found(s_found),
      .i_s_index(s_index), .i_tlbr(tlbr), .i_tlbwi(tlbwi), .i_tlbwr(tlbwr), .o_r_index(r_index),
      .i_r_vpn2(r_vpn2), .i_r_asid(r_asid), .i_r_g(r_g), .i_r_pfn0(r_pfn0), .i_r_c0(r_c0),
      .i_r_d0(r_d0), .i_r_v0(r_v0), .i_r_pfn1(r_pfn1), .i_r_c1(r_c1), .i_r_d1(r_d1), .i_r_v1(r_v1),
      .o_we(we), .o_w_index(w_index), .o_w_vpn2(w_vpn2), .o_w_asid(w_asid), .o_w_g(w_g),
      .o_w_pfn0(w_pfn0), .o_w_c0(w_c0), .o_w_d0(w_d0), .o_w_v0(w_v0), .o_w_pfn1(w_pfn1),
      .o_w_c1(w_c1), .o_w_d1(w_d1), .o_w_v1(w_v1), .o_entryhi_vpn2(entryhi_vpn2),
      .o_entryhi_asid(entryhi_asid), .o_has_int(has_int), .o_cancel(cancel), .o_new_pc(new_pc)
   );

   int n_chk = 0;
   int n_err = 0;

   // Architectural reference state, kept in software-visible (read) format.
   logic        m_p, m_bd, m_ti;
   logic [3:0]  m_idx, m_rnd, m_wired;
   logic [31:0] m_lo0, m_lo1, m_ehi, m_badv, m_count, m_compare, m_status, m_epc;
   logic [5:0]  m_iphw;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_code;
   int          m_pre;

   task automatic model_reset();
      m_p = 0; m_idx = 0; m_rnd = 4'(N - 1); m_wired = 0; m_lo0 = 0; m_lo1 = 0; m_ehi = 0;
      m_badv = 0; m_count = 0; m_compare = 32'hffffffff; m_status = 32'h00400000; m_epc = 0;
      m_bd = 0; m_ti = 0; m_iphw = 0; m_ipsw = 0; m_code = 0; m_pre = 0;
   endtask

   task automatic model_step();
      bit tlbok, do_mt, tick, hit;
      int a;
      tlbok = !ex && !eret;
      do_mt = mtc0_we && !(ex || eret || tlbp || tlbr || tlbwi || tlbwr);
      a     = do_mt ? int'(cp0_waddr) : -1;
      tick  = (m_pre == (1 << DIV) - 1);
      hit   = (m_count == m_compare);
      if (a == 48 || m_rnd == m_wired) m_rnd = 4'(N - 1); else m_rnd = m_rnd - 4'd1;
      if (a == 48) m_wired = cp0_wdata[3:0];
      if (tlbp && tlbok) begin m_p = !s_found; m_idx = s_index; end
      if (a == 0)  m_idx = cp0_wdata[3:0];
      if (tlbr && tlbok) begin
         m_ehi = {r_vpn2, 5'd0, r_asid};
         m_lo0 = {6'd0, r_pfn0, r_c0, r_d0, r_v0, r_g};
         m_lo1 = {6'd0, r_pfn1, r_c1, r_d1, r_v1, r_g};
      end
      if (a == 16) m_lo0 = cp0_wdata & 32'h03ffffff;
      if (a == 24) m_lo1 = cp0_wdata & 32'h03ffffff;
      if (a == 80) m_ehi = cp0_wdata & 32'hffffe0ff;
      if (ex && exccode >= 1 && exccode <= 3) m_ehi[31:13] = badvaddr[31:13];
      if (ex && exccode >= 1 && exccode <= 5) m_badv = badvaddr;
      if (ex && !m_status[1]) begin m_bd = bd; m_epc = bd ? pc - 32'd4 : pc; end
      if (ex) begin m_code = exccode; m_status[1] = 1'b1; end
      if (eret && !ex) m_status[1] = 1'b0;
      if (a == 96)  m_status = (cp0_wdata & 32'h0000ff03) | 32'h00400000;
      if (a == 104) m_ipsw = cp0_wdata[9:8];
      if (a == 112) m_epc = cp0_wdata;
      m_iphw = ext_int_in;
      if (a == 72) m_count = cp0_wdata; else if (tick) m_count = m_count + 32'd1;
      m_pre = (m_pre + 1) % (1 << DIV);
      if (a == 88) begin m_compare = cp0_wdata; m_ti = 0; end else if (hit) m_ti = 1;
   endtask

   always @(posedge clk or posedge reset)
      if (reset) model_reset(); else model_step();

   function automatic logic [7:0] m_ip();
      return {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
   endfunction

   function automatic logic [31:0] exp_read(input logic [7:0] a);
      case (a)
         0:   return {m_p, 27'd0, m_idx};
         8:   return {28'd0, m_rnd};
         16:  return m_lo0;
         24:  return m_lo1;
         48:  return {28'd0, m_wired};
         64:  return m_badv;
         72:  return m_count;
         80:  return m_ehi;
         88:  return m_compare;
         96:  return m_status;
         104: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'd0};
         112: return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] exp_newpc();
      if (reset) return EB + 32'h180;
      if (ex)    return (refill && !m_status[1]) ? EB : EB + 32'h180;
      if (eret)  return m_epc;
      if (tlbr || tlbwi || tlbwr) return pc + 32'd4;
      return EB + 32'h180;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [7:0] a, input string tag);
      cp0_raddr = a; #1;
      chk(tag, cp0_rdata, exp_read(a));
   endtask

   task automatic rdk(input logic [7:0] a, input string tag, input logic [31:0] lit);
      cp0_raddr = a; #1;
      chk(tag, cp0_rdata, lit);
      chk({tag, "_model"}, cp0_rdata, exp_read(a));
   endtask

   task automatic chk_comb();
      bit ewe;
      #1;
      ewe = !reset && (tlbwi || tlbwr) && !ex && !eret;
      chk("cancel", 32'(cancel), 32'(!reset && (ex || eret || tlbr || tlbwi || tlbwr)));
      chk("we", 32'(we), 32'(ewe));
      if (ewe) chk("w_index", 32'(w_index), 32'(tlbwr ? m_rnd : m_idx));
      chk("new_pc", new_pc, exp_newpc());
      chk("has_int", 32'(has_int),
          32'((|(m_ip() & m_status[15:8])) && m_status[0] && !m_status[1]));
      chk("r_index", 32'(r_index), 32'(m_idx));
      chk("entryhi", {entryhi_vpn2, 5'd0, entryhi_asid}, m_ehi);
      chk("w_g", 32'(w_g), 32'(m_lo0[0] & m_lo1[0]));
   endtask

   task automatic clk1();
      @(posedge clk); #1;
      ex = 0; eret = 0; mtc0_we = 0; tlbp = 0; tlbr = 0; tlbwi = 0; tlbwr = 0;
   endtask

   task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
      mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
      clk1();
   endtask

   task automatic rand_tlb_read();
      r_vpn2 = 19'($urandom); r_asid = 8'($urandom); r_g = 1'($urandom);
      r_pfn0 = 20'($urandom); r_c0 = 3'($urandom); r_d0 = 1'($urandom); r_v0 = 1'($urandom);
      r_pfn1 = 20'($urandom); r_c1 = 3'($urandom); r_d1 = 1'($urandom); r_v1 = 1'($urandom);
   endtask

   logic [7:0] addr_tab [14] = '{0, 8, 16, 24, 48, 64, 72, 80, 88, 96, 104, 112, 120, 1};
   logic [7:0] wadr_tab [12] = '{0, 8, 16, 24, 48, 72, 80, 88, 96, 104, 112, 121};

   initial begin
      int c;
      bit seen;
      reset = 1; ex = 1; eret = 0; mtc0_we = 0; tlbp = 0; tlbr = 0; tlbwi = 1; tlbwr = 0;
      exccode = 5'd8; bd = 0; pc = 32'h100; badvaddr = 0; refill = 0; ext_int_in = 0;
      cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0; s_found = 0; s_index = 0;
      rand_tlb_read();
      #20;
      chk("rst_cancel", 32'(cancel), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_new_pc", new_pc, EB + 32'h180);
      repeat (3) @(posedge clk);
      #1; ex = 0; tlbwi = 0; #5;
      reset = 0;

      // Reset state (strobes held during reset must have had no effect).
      rdk(96, "rst_status", 32'h00400000);
      rdk(8, "rst_random", 32'd15);
      rdk(88, "rst_compare", 32'hffffffff);
      chk("rst_has_int", 32'(has_int), 32'd0);
      for (int i = 0; i < 14; i++) if (addr_tab[i] != 96) rd(addr_tab[i], "rst_reg");
      chk_comb();

      // Wired=3: Random walks 15..3 then wraps; tlbwr at Random=7.
      mtc0(48, 3);
      for (int i = 0; i < 14; i++) begin
         rdk(8, "random_seq", (i == 13) ? 32'd15 : 32'(15 - i));
         if (i == 8) begin
            tlbwr = 1; pc = 32'h2000; #1;
            chk("tlbwr_we", 32'(we), 32'd1);
            chk("tlbwr_idx", 32'(w_index), 32'd7);
            chk("tlbwr_pc", new_pc, 32'h2004);
            chk_comb();
         end
         clk1();
      end

      // TLB refill exception in a delay slot, then a nested one.
      ex = 1; exccode = 2; pc = 32'h80001004; bd = 1; badvaddr = 32'h00402abc; refill = 1;
      #1; chk("ex1_new_pc", new_pc, 32'hbfc00200);
      chk_comb();
      clk1();
      rdk(112, "ex1_epc", 32'h80001000);
      cp0_raddr = 104; #1; chk("ex1_bd", 32'(cp0_rdata[31]), 32'd1);
      chk("ex1_code", 32'(cp0_rdata[6:2]), 32'd2);
      cp0_raddr = 80; #1; chk("ex1_vpn2", 32'(cp0_rdata[31:13]), 32'h00201);
      rdk(64, "ex1_badv", 32'h00402abc);
      ex = 1; exccode = 3; pc = 32'h80003000; bd = 0; refill = 1;
      #1; chk("ex2_new_pc", new_pc, 32'hbfc00380);
      clk1();
      rdk(112, "ex2_epc", 32'h80001000);
      eret = 1; #1; chk("eret_pc", new_pc, 32'h80001000);
      chk_comb();
      clk1();
      cp0_raddr = 96; #1; chk("eret_exl", 32'(cp0_rdata[1]), 32'd0);

      // Timer: Compare=5, Count=0, IM7 and IE enabled.
      mtc0(96, 32'h8001);
      mtc0(88, 5);
      mtc0(72, 0);
      seen = 0; c = 0;
      while (!seen && c < 40) begin
         chk_comb();
         if (has_int) seen = 1; else begin c++; clk1(); end
      end
      chk("ti_seen", 32'(seen), 32'd1);
      chk("ti_delay_ok", 32'(c >= 9 && c <= 12), 32'd1);
      cp0_raddr = 104; #1; chk("ti_bit", 32'(cp0_rdata[30]), 32'd1);
      mtc0(88, 1000);
      cp0_raddr = 104; #1; chk("ti_clear", 32'(cp0_rdata[30]), 32'd0);
      chk("ti_has_int", 32'(has_int), 32'd0);

      // tlbp miss, then tlbwi.
      tlbp = 1; s_found = 0; s_index = 4; clk1();
      rdk(0, "tlbp_index", 32'h80000004);
      tlbwi = 1; pc = 32'h1000; #1;
      chk("tlbwi_cancel", 32'(cancel), 32'd1);
      chk("tlbwi_pc", new_pc, 32'h1004);
      chk("tlbwi_idx", 32'(w_index), 32'd4);
      chk_comb();
      clk1();

      // ex beats a simultaneous mtc0 Status.
      ex = 1; exccode = 8; refill = 0; mtc0_we = 1; cp0_waddr = 96; cp0_wdata = 0;
      chk_comb();
      clk1();
      rdk(96, "ex_vs_mtc0", 32'h00408003);
      eret = 1; clk1();

      // tlbr loads EntryHi/EntryLo the next cycle.
      r_vpn2 = 19'h12345; r_asid = 8'h5a; r_g = 1;
      tlbr = 1; pc = 32'h3000; chk_comb(); clk1();
      rdk(80, "tlbr_ehi", {19'h12345, 5'd0, 8'h5a});
      rd(16, "tlbr_lo0"); rd(24, "tlbr_lo1");
      chk("tlbr_w_g", 32'(w_g), 32'd1);

      // Randomized traffic against the reference model.
      for (int it = 0; it < 500; it++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 3) == 0) ext_int_in = 6'($urandom);
         pc = $urandom & 32'hfffffffc; exccode = 5'($urandom_range(0, 12));
         bd = 1'($urandom); refill = 1'($urandom); badvaddr = $urandom;
         cp0_waddr = wadr_tab[$urandom_range(0, 11)]; cp0_wdata = $urandom;
         if (r < 40)      mtc0_we = 1;
         else if (r < 46) ex = 1;
         else if (r < 52) eret = 1;
         else if (r < 60) begin tlbp = 1; s_found = 1'($urandom); s_index = 4'($urandom); end
         else if (r < 66) begin tlbr = 1; rand_tlb_read(); end
         else if (r < 72) tlbwi = 1;
         else if (r < 78) tlbwr = 1;
         else if (r < 86) begin
            ex = 1'($urandom); eret = 1'($urandom); mtc0_we = 1;
            tlbwi = 1'($urandom); tlbwr = 1'($urandom); tlbp = 1'($urandom);
         end
         chk_comb();
         clk1();
         rd(addr_tab[$urandom_range(0, 13)], "rand_read");
      end

      // Reset mid-cycle clears state at once; strobes ignored while it is high.
      ex = 1; tlbwi = 1; #10;
      reset = 1; #1;
      rdk(96, "midrst_status", 32'h00400000);
      rdk(72, "midrst_count", 32'd0);
      rdk(8, "midrst_random", 32'd15);
      chk("midrst_has_int", 32'(has_int), 32'd0);
      chk("midrst_cancel", 32'(cancel), 32'd0);
      @(posedge clk); #1;
      rdk(96, "rsthold_status", 32'h00400000);
      ex = 0; tlbwi = 0; reset = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/cp0_tlb_regfile.md
# cp0_tlb_regfile

Parametrised CP0 register file and exception/TLB-maintenance controller, instantiated beside the writeback stage. It holds all privileged state, timer, interrupt pending logic and the TLB maintenance registers, sized by `TLBNUM`. It adds Random/Wired registers, `tlbwr`, TLB-exception EntryHi/BadVAddr capture, a refill vector and a configurable Count prescaler. Writeback drives one-cycle commit strobes; the block returns read data, redirect PC and cancel.

## Interface
- `TLBNUM`, 16: TLB entries; power of two, 2..64; `IDXW = log2(TLBNUM)`
- `CNT_DIV_LOG2`, 1: Count increments once per `2**CNT_DIV_LOG2` cycles; 0 means every cycle
- `EXC_BASE`, 32'hbfc00200: refill vector; general vector is `EXC_BASE+0x180`
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high reset
- `ext_int_in` in 6: hardware interrupt lines, level
- `ex` in 1: exception commit strobe; `exccode` in 5, `bd` in 1, `pc` in 32, `badvaddr` in 32, `refill` in 1 (TLB miss, not invalid)
- `eret` in 1: eret commit strobe
- `mtc0_we` in 1, `cp0_waddr` in 8, `cp0_wdata` in 32: register write ({rd,sel})
- `cp0_raddr` in 8 / `cp0_rdata` out 32: combinational read
- `tlbp` in 1, `s_found` in 1, `s_index` in IDXW: probe result
- `tlbr` in 1, `tlbwi` in 1, `tlbwr` in 1: TLB op commit strobes
- `r_index` out IDXW; `r_vpn2` 19, `r_asid` 8, `r_g` 1, `r_pfn0/1` 20, `r_c0/1` 3, `r_d0/1` 1, `r_v0/1` 1 in: TLB read port
- `we` out 1, `w_index` out IDXW, `w_vpn2/w_asid/w_g/w_pfn0/w_c0/w_d0/w_v0/w_pfn1/w_c1/w_d1/w_v1` out: TLB write port
- `entryhi_vpn2` out 19, `entryhi_asid` out 8: to TLB search ports
- `has_int` out 1; `cancel` out 1; `new_pc` out 32

## Operation
- Addresses: Index 0, Random 8, EntryLo0 16, EntryLo1 24, Wired 48, BadVAddr 64, Count 72, EntryHi 80, Compare 88, Status 96, Cause 104, EPC 112; others read 0, writes ignored.
- Strobe priority when several assert: `ex` > `eret` > `tlbr/tlbwi/tlbwr/tlbp` > `mtc0_we`; lower ones dropped that cycle.
- Index: {P,0,index}; tlbp loads P=!s_found, index=s_index. Random: read-only, reset TLBNUM-1; decrements every cycle; at value == Wired next value is TLBNUM-1; any Wired write resets it to TLBNUM-1.
- Wired: low IDXW bits writable, reset 0.
- EntryLo0/1 {6'b0,PFN,C,D,V,G}, EntryHi {VPN2,5'b0,ASID}: mtc0 or tlbr load (G from r_g into both). On `ex` with exccode 1/2/3 EntryHi.VPN2 <= badvaddr[31:13].
- BadVAddr loads badvaddr on `ex` with exccode 1,2,3,4,5.
- Status: BEV=1 read-only, IM[15:8], EXL[1], IE[0]; `ex` sets EXL, `eret` clears it.
- Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]. IP[7:2] registered each cycle from ext_int_in, IP7 ORed with TI; IP[1:0] writable. BD and EPC (pc, or pc-4 when bd) update on `ex` only if EXL=0. ExcCode updates on every `ex`.
- Count: prescaler, increments on tick; mtc0 overrides. Compare reset 32'hffffffff. TI sets when Count==Compare, cleared by mtc0 Compare (wins).
- TLB write: we = tlbwi|tlbwr; w_index = tlbwr ? Random : Index.index; w_g = G0&G1. r_index = Index.index.
- has_int = |(IP & IM) & IE & !EXL.
- cancel = ex|eret|tlbr|tlbwi|tlbwr. new_pc: TLB op -> pc+4; eret -> EPC; ex with refill & !EXL -> EXC_BASE; other ex -> EXC_BASE+0x180.

## Timing
- Reset: Index/Wired/EntryLo/EntryHi/BadVAddr/EPC/Count/Cause 0, Random TLBNUM-1, Compare 32'hffffffff, Status 0x00400000, prescaler 0. Outputs: we 0, cancel 0, has_int 0, new_pc EXC_BASE+0x180.
- All updates at the next rising edge; cp0_rdata, cancel, new_pc, we combinational; mtc0 in cycle N visible to a read in N+1.
- IP[7:2] lags ext_int_in by one cycle; has_int one more combinational step.
- tlbr: r_* sampled in the strobe cycle, EntryHi/Lo valid next cycle.
- Reset asserted mid-operation clears state immediately; strobes ignored while reset high.

## Test plan
- Reset release: read Status -> 0x00400000, Random -> TLBNUM-1, Compare -> 0xffffffff, has_int 0.
- Write Wired=3 (TLBNUM=16): Random reads 15,14..3,15; tlbwr when Random=7 -> we=1, w_index=7.
- ex exccode=2, pc=0x80001004, bd=1, badvaddr=0x00402abc, refill=1, EXL=0 -> EPC 0x80001000, BD 1, EntryHi.VPN2 0x00201, new_pc 0xbfc00200; second ex with EXL=1 -> EPC unchanged, new_pc 0xbfc00380.
- Compare=5, Count=0, CNT_DIV_LOG2=1 -> TI set ~10 cycles later; IM7=1, IE=1 -> has_int 1; mtc0 Compare clears TI.
- tlbp s_found=0 s_index=4 -> Index 0x80000004; tlbwi pc=0x1000 -> cancel 1, new_pc 0x1004.
- Simultaneous ex and mtc0 Status -> mtc0 dropped, EXL=1.
